// File: rtl/sym2x2_eig_pkg.sv
// Shared widths and FSM encoding for the symmetric 2x2 eigensolver and its helpers.
// All outputs carry DIN_POINT fractional bits, the same point as the inputs.
package sym2x2_eig_pkg;

    localparam int DIN_WIDTH  = 32;
    localparam int DIN_POINT  = 16;
    localparam int SQ_WIDTH   = 2*DIN_WIDTH + 2;
    localparam int ROOT_WIDTH = DIN_WIDTH + 1;
    localparam int LAMB_WIDTH = DIN_WIDTH + 1;
    localparam int VEC_WIDTH  = DIN_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SQR,
        SQRT,
        FIN
    } state_t;

endpackage

// File: rtl/sym2x2_eig_if.sv
// Matrix-in / eigen-result-out bundle between the correlation stage, the eigensolver and the DOA stage.
// The master drives the matrix elements; the slave (the eigensolver) returns the results.
interface sym2x2_eig_if;
    import sym2x2_eig_pkg::*;

    logic signed [DIN_WIDTH-1:0]  r11;
    logic signed [DIN_WIDTH-1:0]  r22;
    logic signed [DIN_WIDTH-1:0]  r12;
    logic                         din_valid;
    logic signed [LAMB_WIDTH-1:0] lamb_max;
    logic signed [LAMB_WIDTH-1:0] lamb_min;
    logic signed [VEC_WIDTH-1:0]  vec_x;
    logic signed [VEC_WIDTH-1:0]  vec_y;
    logic                         degen;
    logic                         dout_valid;
    logic                         busy;
    logic                         din_drop;

    modport master (
        output r11, r22, r12, din_valid,
        input  lamb_max, lamb_min, vec_x, vec_y, degen, dout_valid, busy, din_drop
    );

    modport slave (
        input  r11, r22, r12, din_valid,
        output lamb_max, lamb_min, vec_x, vec_y, degen, dout_valid, busy, din_drop
    );

endinterface

// File: rtl/sym2x2_eig_isqrt_serial.sv
// Serial non-restoring integer square root: one root bit per cycle, root = floor(sqrt(radicand)).
// The first digit is resolved on the start edge, so done rises ROOT_W cycles after start.
module isqrt_serial
    import sym2x2_eig_pkg::*;
#(
    parameter  int ROOT_W = ROOT_WIDTH,
    localparam int RAD_W  = 2*ROOT_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAD_W-1:0]  radicand,
    output logic [ROOT_W-1:0] root,
    output logic              done
);

    localparam int REM_W = ROOT_W + 4;
    localparam int CNT_W = $clog2(ROOT_W);

    logic signed [REM_W-1:0] rem_q;
    logic signed [REM_W-1:0] src_rem;
    logic signed [REM_W-1:0] shifted;
    logic signed [REM_W-1:0] rem_n;
    logic [ROOT_W-1:0]       root_q;
    logic [ROOT_W-1:0]       src_root;
    logic [ROOT_W-1:0]       root_n;
    logic [RAD_W-1:0]        rad_q;
    logic [1:0]              src_bits;
    logic [CNT_W-1:0]        cnt_q;
    logic                    active_q;

    // A negative partial remainder is not restored; the next digit adds instead of subtracting.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        src_bits = start ? radicand[RAD_W-1 -: 2] : rad_q[RAD_W-1 -: 2];
        shifted  = (src_rem <<< 2) | REM_W'(src_bits);
        if (src_rem[REM_W-1])
            rem_n = shifted + REM_W'({src_root, 2'b11});
        else
            rem_n = shifted - REM_W'({src_root, 2'b01});
        root_n = {src_root[ROOT_W-2:0], ~rem_n[REM_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            root_q   <= '0;
            rad_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= rem_n;
                root_q   <= root_n;
                rad_q    <= {radicand[RAD_W-3:0], 2'b00};
                cnt_q    <= CNT_W'(ROOT_W - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q  <= rem_n;
                root_q <= root_n;
                rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
                cnt_q  <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

    assign root = root_q;

endmodule

// File: rtl/sym2x2_eig.sv
// Eigendecomposition of a real symmetric 2x2 matrix: both eigenvalues plus the unnormalised
// dominant eigenvector, one matrix in flight at a time.
module sym2x2_eig
    import sym2x2_eig_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    sym2x2_eig_if.slave bus
);

    state_t state_q;
    state_t state_n;

    logic signed [DIN_WIDTH-1:0]  r11_q, r22_q, r12_q;
    logic signed [LAMB_WIDTH-1:0] d_q, s_q;
    logic                         sel_q;
    logic                         busy, accept, sqrt_start, fin;
    logic                         sqrt_done;
    logic [ROOT_WIDTH-1:0]        root;
    logic signed [SQ_WIDTH-1:0]   d_sq, r12_sq;
    logic [SQ_WIDTH-1:0]          q_sum;
    logic signed [LAMB_WIDTH:0]   max_sum, min_sum;
    logic signed [LAMB_WIDTH-1:0] lmax_n, lmin_n;
    logic signed [VEC_WIDTH-1:0]  vx_n, vy_n;
    logic                         degen_n;

    logic signed [LAMB_WIDTH-1:0] lamb_max_q, lamb_min_q;
    logic signed [VEC_WIDTH-1:0]  vec_x_q, vec_y_q;
    logic                         degen_q, dout_valid_q, din_drop_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_n = PREP;
            PREP:    state_n = SQR;
            SQR:     state_n = SQRT;
            SQRT:    if (sqrt_done) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The dout_valid cycle still counts as busy, so a matrix offered then is dropped.
    always_comb begin
        busy       = (state_q != IDLE) || dout_valid_q;
        accept     = bus.din_valid && !busy;
        sqrt_start = (state_q == SQR);
        fin        = (state_q == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r11_q <= '0;
            r22_q <= '0;
            r12_q <= '0;
            d_q   <= '0;
            s_q   <= '0;
            sel_q <= 1'b0;
        end else begin
            if (accept) begin
                r11_q <= bus.r11;
                r22_q <= bus.r22;
                r12_q <= bus.r12;
            end
            if (state_q == PREP) begin
                d_q   <= LAMB_WIDTH'(r11_q) - LAMB_WIDTH'(r22_q);
                s_q   <= LAMB_WIDTH'(r11_q) + LAMB_WIDTH'(r22_q);
                sel_q <= (r11_q >= r22_q);
            end
        end
    end

    // Discriminant (r11-r22)^2 + 4*r12^2 is non-negative and always fits SQ_WIDTH unsigned bits.
    always_comb begin
        d_sq   = d_q * d_q;
        r12_sq = r12_q * r12_q;
        q_sum  = $unsigned(d_sq) + ($unsigned(r12_sq) << 2);
    end

    isqrt_serial #(
        .ROOT_W   (ROOT_WIDTH)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (q_sum),
        .root     (root),
        .done     (sqrt_done)
    );

    // Vector uses whichever row form keeps the larger-magnitude difference, avoiding cancellation.
    always_comb begin
        max_sum = (LAMB_WIDTH+1)'(s_q) + (LAMB_WIDTH+1)'(root);
        min_sum = (LAMB_WIDTH+1)'(s_q) - (LAMB_WIDTH+1)'(root);
        lmax_n  = LAMB_WIDTH'(max_sum >>> 1);
        lmin_n  = LAMB_WIDTH'(min_sum >>> 1);
        degen_n = (d_q == '0) && (r12_q == '0);
        vx_n    = '0;
        vy_n    = '0;
        if (!degen_n) begin
            if (sel_q) begin
                vx_n = VEC_WIDTH'(lmax_n) - VEC_WIDTH'(r22_q);
                vy_n = VEC_WIDTH'(r12_q);
            end else begin
                vx_n = VEC_WIDTH'(r12_q);
                vy_n = VEC_WIDTH'(lmax_n) - VEC_WIDTH'(r11_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lamb_max_q   <= '0;
            lamb_min_q   <= '0;
            vec_x_q      <= '0;
            vec_y_q      <= '0;
            degen_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            din_drop_q   <= 1'b0;
        end else begin
            dout_valid_q <= fin;
            din_drop_q   <= bus.din_valid && busy;
            if (fin) begin
                lamb_max_q <= lmax_n;
                lamb_min_q <= lmin_n;
                vec_x_q    <= vx_n;
                vec_y_q    <= vy_n;
                degen_q    <= degen_n;
            end
        end
    end

    assign bus.lamb_max   = lamb_max_q;
    assign bus.lamb_min   = lamb_min_q;
    assign bus.vec_x      = vec_x_q;
    assign bus.vec_y      = vec_y_q;
    assign bus.degen      = degen_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy;
    assign bus.din_drop   = din_drop_q;

endmodule

// File: tb/tb_sym2x2_eig.sv
// Bench for sym2x2_eig: directed spec cases, drop/abort timing and random matrices checked
// against an exact wide-integer eigen model plus a real-valued eigenvalue model.
module tb_sym2x2_eig;
    import sym2x2_eig_pkg::*;

    localparam int ONE     = 1 << DIN_POINT;
    localparam int LATENCY = DIN_WIDTH + 5;

    typedef struct packed {
        logic signed [LAMB_WIDTH-1:0] lmax;
        logic signed [LAMB_WIDTH-1:0] lmin;
        logic signed [VEC_WIDTH-1:0]  vx;
        logic signed [VEC_WIDTH-1:0]  vy;
        logic                         degen;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sym2x2_eig_if bus();

    sym2x2_eig dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Greedy bitwise integer square root on wide arithmetic.
    function automatic logic [127:0] int_sqrt(input logic [127:0] x);
        logic [127:0] r;
        logic [127:0] c;
        r = '0;
        for (int b = 40; b >= 0; b--) begin
            c = r | (128'd1 << b);
            if (c * c <= x) r = c;
        end
        return r;
    endfunction

    // Closed-form eigenpair of [a c; c b] with floor-halved eigenvalues.
    function automatic result_t model(input logic signed [DIN_WIDTH-1:0] a, b, c);
        logic signed [127:0] wa, wb, wc, d, s, root, lmax, lmin, t;
        result_t res;
        wa   = a;
        wb   = b;
        wc   = c;
        d    = wa - wb;
        s    = wa + wb;
        root = $signed(int_sqrt($unsigned(d*d + 4*wc*wc)));
        lmax = (s + root) >>> 1;
        lmin = (s - root) >>> 1;
        res.lmax  = lmax[LAMB_WIDTH-1:0];
        res.lmin  = lmin[LAMB_WIDTH-1:0];
        res.degen = (d == 0) && (wc == 0);
        res.vx    = '0;
        res.vy    = '0;
        if (!res.degen) begin
            if (wa >= wb) begin
                t      = lmax - wb;
                res.vx = t[VEC_WIDTH-1:0];
                res.vy = wc[VEC_WIDTH-1:0];
            end else begin
                t      = lmax - wa;
                res.vx = wc[VEC_WIDTH-1:0];
                res.vy = t[VEC_WIDTH-1:0];
            end
        end
        return res;
    endfunction

    function automatic real real_lmax(input logic signed [DIN_WIDTH-1:0] a, b, c);
        real ra, rb, rc, d;
        ra = a;
        rb = b;
        rc = c;
        d  = ra - rb;
        return (ra + rb + $sqrt(d*d + 4.0*rc*rc)) / 2.0;
    endfunction

    function automatic string fmt(input result_t r);
        return $sformatf("lmax=%0d lmin=%0d vx=%0d vy=%0d degen=%0b", r.lmax, r.lmin, r.vx, r.vy, r.degen);
    endfunction

    function automatic result_t observed();
        result_t r;
        r = {bus.lamb_max, bus.lamb_min, bus.vec_x, bus.vec_y, bus.degen};
        return r;
    endfunction

    task automatic drive(input logic signed [DIN_WIDTH-1:0] a, b, c);
        bus.r11       = a;
        bus.r22       = b;
        bus.r12       = c;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_dout(input int start, output int lat, output bit seen);
        lat  = start;
        seen = 1'b0;
        for (int i = 0; i < 2*LATENCY; i++) begin
            if (bus.dout_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.din_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({observed(), bus.dout_valid, bus.busy, bus.din_drop} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %s dv=%0b busy=%0b drop=%0b, expected all zero",
                     fmt(observed()), bus.dout_valid, bus.busy, bus.din_drop);
        end
        bus.din_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.din_drop !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got busy=%0b drop=%0b, expected 0 0", bus.busy, bus.din_drop);
        end
    endtask

    task automatic test_directed();
        int t11[5] = '{3, 2,  1, 1, 1};
        int t22[5] = '{1, 2,  1, 4, 1};
        int t12[5] = '{0, 1, -1, 0, 0};
        int tmx[5] = '{3, 3,  2, 4, 1};
        int tmn[5] = '{1, 1,  0, 1, 1};
        int tvx[5] = '{2, 1,  1, 0, 0};
        int tvy[5] = '{0, 1, -1, 3, 0};
        int tdg[5] = '{0, 0,  0, 0, 1};
        result_t exp_r;
        int lat;
        bit seen;
        for (int k = 0; k < 5; k++) begin
            exp_r.lmax  = LAMB_WIDTH'(tmx[k] * ONE);
            exp_r.lmin  = LAMB_WIDTH'(tmn[k] * ONE);
            exp_r.vx    = VEC_WIDTH'(tvx[k] * ONE);
            exp_r.vy    = VEC_WIDTH'(tvy[k] * ONE);
            exp_r.degen = tdg[k][0];
            @(negedge clk);
            drive(t11[k] * ONE, t22[k] * ONE, t12[k] * ONE);
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL directed%0d_busy: got %0b, expected 1 at cycle 1", k, bus.busy);
            end
            wait_dout(1, lat, seen);
            n_checks++;
            if (!seen || lat != LATENCY) begin
                n_fail++;
                $display("[TB] FAIL directed%0d_latency: got %0d (seen=%0b), expected %0d", k, lat, seen, LATENCY);
            end
            n_checks++;
            if (observed() !== exp_r) begin
                n_fail++;
                $display("[TB] FAIL directed%0d_result: got %s, expected %s", k, fmt(observed()), fmt(exp_r));
            end
        end
    endtask

    task automatic test_drop_and_reset();
        result_t exp1, exp3;
        int lat;
        int drops;
        bit seen;
        bit seen_dv;
        exp1 = model(5*ONE/2, ONE/2, -3*ONE/4);
        exp3 = model(-ONE, 6*ONE, 2*ONE);
        @(negedge clk);
        drive(5*ONE/2, ONE/2, -3*ONE/4);
        drops = 0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            drops += int'(bus.din_drop);
            @(negedge clk);
        end
        drive(7*ONE, 7*ONE, 7*ONE);
        n_checks++;
        if (bus.din_drop !== 1'b1 || drops != 0) begin
            n_fail++;
            $display("[TB] FAIL drop_pulse: got drop=%0b at cycle 11 (%0d earlier), expected 1 (0 earlier)", bus.din_drop, drops);
        end
        @(negedge clk);
        n_checks++;
        if (bus.din_drop !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drop_width: got %0b at cycle 12, expected 0", bus.din_drop);
        end
        wait_dout(12, lat, seen);
        n_checks++;
        if (!seen || lat != LATENCY) begin
            n_fail++;
            $display("[TB] FAIL drop_latency: got %0d (seen=%0b), expected %0d", lat, seen, LATENCY);
        end
        n_checks++;
        if (observed() !== exp1) begin
            n_fail++;
            $display("[TB] FAIL drop_result: got %s, expected %s", fmt(observed()), fmt(exp1));
        end
        @(negedge clk);
        drive(ONE, 2*ONE, 3*ONE);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({observed(), bus.dout_valid, bus.busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL abort_state: got %s dv=%0b busy=%0b, expected all zero",
                     fmt(observed()), bus.dout_valid, bus.busy);
        end
        seen_dv = 1'b0;
        repeat (2*LATENCY) begin
            if (bus.dout_valid) seen_dv = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_dv) begin
            n_fail++;
            $display("[TB] FAIL abort_silent: got dout_valid=1 after reset, expected none");
        end
        drive(-ONE, 6*ONE, 2*ONE);
        wait_dout(1, lat, seen);
        n_checks++;
        if (!seen || lat != LATENCY || observed() !== exp3) begin
            n_fail++;
            $display("[TB] FAIL post_abort: got lat=%0d seen=%0b %s, expected lat=%0d %s",
                     lat, seen, fmt(observed()), LATENCY, fmt(exp3));
        end
    endtask

    task automatic test_back_to_back();
        result_t exp_a, exp_c;
        int lat;
        bit seen;
        exp_a = model(4*ONE, -ONE, ONE/3);
        exp_c = model(-2*ONE, -5*ONE, -ONE);
        @(negedge clk);
        drive(4*ONE, -ONE, ONE/3);
        wait_dout(1, lat, seen);
        n_checks++;
        if (!seen || observed() !== exp_a) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got seen=%0b %s, expected %s", seen, fmt(observed()), fmt(exp_a));
        end
        drive(9*ONE, 9*ONE, 9*ONE);
        n_checks++;
        if (bus.din_drop !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_dout_cycle_drop: got drop=%0b busy=%0b, expected 1 0", bus.din_drop, bus.busy);
        end
        drive(-2*ONE, -5*ONE, -ONE);
        n_checks++;
        if (bus.din_drop !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept: got drop=%0b busy=%0b, expected 0 1", bus.din_drop, bus.busy);
        end
        wait_dout(1, lat, seen);
        n_checks++;
        if (!seen || lat != LATENCY || observed() !== exp_c) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got lat=%0d seen=%0b %s, expected lat=%0d %s",
                     lat, seen, fmt(observed()), LATENCY, fmt(exp_c));
        end
    endtask

    task automatic test_random();
        logic signed [DIN_WIDTH-1:0] a, b, c;
        result_t exp_r;
        real     want, got_l;
        int      lat;
        bit      seen;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = $urandom;
                    b = $urandom;
                    c = $urandom;
                end
                1: begin
                    a = int'($urandom_range(0, 16*ONE)) - 8*ONE;
                    b = int'($urandom_range(0, 16*ONE)) - 8*ONE;
                    c = int'($urandom_range(0, 16*ONE)) - 8*ONE;
                end
                2: begin
                    a = int'($urandom_range(0, 16*ONE)) - 8*ONE;
                    b = a;
                    c = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 4*ONE)) - 2*ONE;
                end
                default: begin
                    a = $urandom;
                    b = $urandom;
                    c = 0;
                end
            endcase
            exp_r = model(a, b, c);
            want  = real_lmax(a, b, c);
            @(negedge clk);
            drive(a, b, c);
            wait_dout(1, lat, seen);
            n_checks++;
            if (!seen || lat != LATENCY) begin
                n_fail++;
                $display("[TB] FAIL random%0d_latency: got %0d (seen=%0b), expected %0d", n, lat, seen, LATENCY);
            end
            n_checks++;
            if (observed() !== exp_r) begin
                n_fail++;
                $display("[TB] FAIL random%0d_result: in r11=%0d r22=%0d r12=%0d got %s, expected %s",
                         n, a, b, c, fmt(observed()), fmt(exp_r));
            end
            got_l = bus.lamb_max;
            n_checks++;
            if (got_l - want > 1.0 || want - got_l > 1.0) begin
                n_fail++;
                $display("[TB] FAIL random%0d_real_lmax: got %0d, expected %f within 1 LSB", n, bus.lamb_max, want);
            end
        end
    endtask

    initial begin
        bus.r11       = '0;
        bus.r22       = '0;
        bus.r12       = '0;
        bus.din_valid = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_drop_and_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
